// File: rtl/serial_adder.sv
// serial_adder: bit-serial N-bit adder built around one full-adder cell and a
// registered carry. Operands are captured on an accepted start and added
// LSB-first, one bit per clock; the parallel sum and carry-out are published
// together with a one-cycle done pulse.
// Optional feature: define SERIAL_ADDER_OVF_EN to add the ovf output, the
// two's-complement signed overflow of the published result.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             c_q, c_d;
  logic [WIDTH-1:0] psum_q, psum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             fa_sum;
  logic             fa_carry;
  logic             last_bit;
`ifdef SERIAL_ADDER_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  // The single full-adder cell operating on the current LSBs and the running carry
  always_comb begin
    fa_sum   = a_q[0] ^ b_q[0] ^ c_q;
    fa_carry = (a_q[0] & b_q[0]) | (c_q & (a_q[0] ^ b_q[0]));
    last_bit = (cnt_q == CW'(WIDTH - 1));
  end

  // Next-state logic: load on accepted start, shift one bit per SHIFT cycle,
  // publish the result on the final bit so it appears on entry to DONE
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    psum_d  = psum_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    carry_d = carry_q;
`ifdef SERIAL_ADDER_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          c_d     = cin;
          cnt_d   = '0;
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        a_d    = {1'b0, a_q[WIDTH-1:1]};
        b_d    = {1'b0, b_q[WIDTH-1:1]};
        c_d    = fa_carry;
        psum_d = {fa_sum, psum_q[WIDTH-1:1]};
        cnt_d  = cnt_q + 1'b1;
        if (last_bit) begin
          sum_d   = {fa_sum, psum_q[WIDTH-1:1]};
          carry_d = fa_carry;
`ifdef SERIAL_ADDER_OVF_EN
          // c_q is the carry into the MSB on the final bit
          ovf_d   = c_q ^ fa_carry;
`endif
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with asynchronous active-low clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      psum_q  <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      psum_q  <= psum_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
`ifdef SERIAL_ADDER_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign busy  = (state_q == SHIFT);
  assign done  = (state_q == DONE);
  assign sum   = sum_q;
  assign carry = carry_q;
`ifdef SERIAL_ADDER_OVF_EN
  assign ovf   = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: scoreboard bench for serial_adder (WIDTH=8). The driver
// pushes the arithmetically expected result and completion cycle whenever a
// start is accepted; a monitor pops and compares on every done pulse.
module tb_serial_adder;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] s;
    logic         c;
    logic         o;
    int           cyc;
  } exp_t;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         carry;
`ifdef SERIAL_ADDER_OVF_EN
  logic         ovf;
`endif

  exp_t expQ[$];
  int   checks   = 0;
  int   failures = 0;
  int   cycleCnt = 0;

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .carry (carry)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  // Free-running clock and a cycle counter of rising edges
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cycleCnt);
    end
  endtask

  // Reference model: plain unsigned/signed integer addition
  function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                 input logic cv, input int cyc);
    exp_t e;
    int total, sa, sb, sr;
    total = int'(av) + int'(bv) + int'(cv);
    sa = av[W-1] ? int'(av) - (1 << W) : int'(av);
    sb = bv[W-1] ? int'(bv) - (1 << W) : int'(bv);
    sr = sa + sb + int'(cv);
    e.s   = total[W-1:0];
    e.c   = total[W];
    e.o   = (sr > (1 << (W-1)) - 1) || (sr < -(1 << (W-1)));
    e.cyc = cyc;
    return e;
  endfunction

  // Monitor: on every done pulse compare against the oldest expectation
  always @(negedge clk) begin
    if (rst_n && done) begin
      checkOutput("busy_and_done", {31'd0, busy}, 32'd0);
      if (expQ.size() == 0) begin
        checkOutput("unexpected_done", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = expQ.pop_front();
        checkOutput("sum", {24'd0, sum}, {24'd0, e.s});
        checkOutput("carry", {31'd0, carry}, {31'd0, e.c});
        checkOutput("done_cycle", cycleCnt, e.cyc);
`ifdef SERIAL_ADDER_OVF_EN
        checkOutput("ovf", {31'd0, ovf}, {31'd0, e.o});
`endif
      end
    end
  end

  // Drive one start that the DUT will accept (it is idle or in DONE);
  // returns the index of the accepting edge
  task automatic applyStimulus(input logic [W-1:0] av, input logic [W-1:0] bv,
                               input logic cv, input bit hold, output int acc);
    @(negedge clk);
    a = av; b = bv; cin = cv; start = 1'b1;
    @(posedge clk);
    #1;
    acc = cycleCnt;
    expQ.push_back(model(av, bv, cv, acc + W));
    if (!hold) start = 1'b0;
  endtask

  task automatic waitDrained(input string name);
    int n;
    n = 0;
    while (expQ.size() != 0 && n < 4 * W) begin
      @(negedge clk);
      #1;
      n++;
    end
    checks++;
    if (expQ.size() != 0) begin
      failures++;
      $display("[TB] FAIL %s_timeout: %0d results outstanding, expected 0", name, expQ.size());
      expQ.delete();
    end
  endtask

  initial begin
    int acc, acc2;
    logic [W-1:0] ra, rb;
    logic rc;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_busy", {31'd0, busy}, 32'd0);
    checkOutput("reset_done", {31'd0, done}, 32'd0);
    checkOutput("reset_sum", {24'd0, sum}, 32'd0);
    checkOutput("reset_carry", {31'd0, carry}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Basic add with busy profile
    applyStimulus(8'h35, 8'h4A, 1'b0, 1'b0, acc);
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      checkOutput("basic_busy", {31'd0, busy}, 32'd1);
    end
    waitDrained("basic");

    // Carry ripple and wrap
    applyStimulus(8'hFF, 8'h01, 1'b0, 1'b0, acc);
    waitDrained("wrap1");
    applyStimulus(8'hFF, 8'hFF, 1'b1, 1'b0, acc);
    waitDrained("wrap2");

    // Start during busy is ignored
    applyStimulus(8'h01, 8'h01, 1'b0, 1'b0, acc);
    repeat (2) @(negedge clk);
    a = 8'hAA; b = 8'h55; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    waitDrained("ignore_start");
    repeat (W + 4) @(negedge clk);

    // Back-to-back with start held high
    applyStimulus(8'h10, 8'h20, 1'b0, 1'b1, acc);
    a = 8'h0F; b = 8'hF1; cin = 1'b0;
    expQ.push_back(model(8'h0F, 8'hF1, 1'b0, acc + W + 1 + W));
    while (cycleCnt < acc + W + 1) begin
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("b2b_hold_sum", {24'd0, sum}, 32'h30);
    checkOutput("b2b_hold_carry", {31'd0, carry}, 32'd0);
    waitDrained("b2b");
    repeat (2) @(negedge clk);

    // Reset mid-operation
    applyStimulus(8'h12, 8'h34, 1'b0, 1'b0, acc);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    expQ.delete();
    #1;
    checkOutput("rst_mid_busy", {31'd0, busy}, 32'd0);
    checkOutput("rst_mid_done", {31'd0, done}, 32'd0);
    checkOutput("rst_mid_sum", {24'd0, sum}, 32'd0);
    checkOutput("rst_mid_carry", {31'd0, carry}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (W + 4) @(negedge clk);
    checkOutput("rst_idle_busy", {31'd0, busy}, 32'd0);
    applyStimulus(8'h01, 8'h02, 1'b0, 1'b0, acc);
    waitDrained("after_reset");

`ifdef SERIAL_ADDER_OVF_EN
    applyStimulus(8'h7F, 8'h01, 1'b0, 1'b0, acc);
    waitDrained("ovf1");
    applyStimulus(8'h80, 8'h80, 1'b0, 1'b0, acc);
    waitDrained("ovf2");
    applyStimulus(8'hFF, 8'h01, 1'b0, 1'b0, acc);
    waitDrained("ovf3");
`endif

    // Randomized operands, occasionally back-to-back
    for (int i = 0; i < 30; i++) begin
      ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        applyStimulus(ra, rb, rc, 1'b1, acc);
        ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
        a = ra; b = rb; cin = rc;
        acc2 = acc + W + 1;
        expQ.push_back(model(ra, rb, rc, acc2 + W));
        while (cycleCnt < acc2) begin
          @(posedge clk);
          #1;
        end
        start = 1'b0;
      end else begin
        applyStimulus(ra, rb, rc, 1'b0, acc);
      end
      waitDrained("random");
    end

    repeat (W + 4) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
